// File: rtl/fp_add_pkg.sv
// Shared constants, IEEE-754 single field slices and FSM state type for the fp adder sequencer.
package fp_add_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(255);

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MAN_HI   = 22;
    localparam int MAN_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMP,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp_add_seq_ctrl_cmp.sv
// Exponent compare for the CMP stage: picks the large operand and the alignment distance.
module comparare_exp
    import fp_add_pkg::*;
(
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    output logic [EXP_W:0]   valoare,
    output logic [EXP_W-1:0] exp
);

    // valoare[EXP_W]=1: A is large and B's mantissa is the one that shifts; ties go to B.
    always_comb begin
        if (exp_a > exp_b) begin
            valoare = {1'b1, exp_a - exp_b};
            exp     = exp_a;
        end else begin
            valoare = {1'b0, exp_b - exp_a};
            exp     = exp_b;
        end
    end

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle single-precision adder sequencer: compare, bit-serial align, add, bit-serial normalise.
// Optional status flags (flag_ovf, flag_zero, flag_inexact) are built when FPADD_STATUS_EN is defined.
//
// state | meaning
// IDLE  | ready for an operand pair
// CMP   | compare exponents, unpack mantissas, catch inf/NaN operands
// ALIGN | shift small mantissa right, one bit per cycle (or zero it outright)
// ADD   | add or subtract magnitudes, handle carry and overflow
// NORM  | shift sum left until the hidden bit is set, then pack
// DONE  | hold result until the consumer accepts it
module fp_add_seq_ctrl
    import fp_add_pkg::*;
#(
    parameter int MAX_ALIGN = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
`ifdef FPADD_STATUS_EN
    ,
    output logic        flag_ovf,
    output logic        flag_zero,
    output logic        flag_inexact
`endif
);

    localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAX_ALIGN);
    localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_TOP   = EXP_MAX - EXP_W'(1);

    state_t            state_q, state_nxt;
    logic [31:0]       a_q, a_nxt, b_q, b_nxt;
    logic [EXP_W-1:0]  diff_q, diff_nxt;
    logic [EXP_W-1:0]  res_exp_q, res_exp_nxt;
    logic [MAN_W:0]    man_l_q, man_l_nxt, man_s_q, man_s_nxt;
    logic [MAN_W:0]    sum_q, sum_nxt;
    logic              sign_l_q, sign_l_nxt, sign_s_q, sign_s_nxt;
    logic              sign_res_q, sign_res_nxt;
    logic [31:0]       result_q, result_nxt;
    logic [MAN_W+1:0]  add_sum;

    logic [EXP_W-1:0]  exp_a, exp_b, cmp_exp;
    logic [EXP_W:0]    cmp_val;
    logic [MAN_W:0]    man_a, man_b;

`ifdef FPADD_STATUS_EN
    logic ovf_q, ovf_nxt, zero_q, zero_nxt, inx_q, inx_nxt;
`endif

    assign exp_a = a_q[EXP_HI:EXP_LO];
    assign exp_b = b_q[EXP_HI:EXP_LO];
    // Zero exponent flushes the operand to zero, subnormals included.
    assign man_a = (exp_a != '0) ? {1'b1, a_q[MAN_HI:MAN_LO]} : '0;
    assign man_b = (exp_b != '0) ? {1'b1, b_q[MAN_HI:MAN_LO]} : '0;

    comparare_exp u_cmp (
        .exp_a   (exp_a),
        .exp_b   (exp_b),
        .valoare (cmp_val),
        .exp     (cmp_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            res_exp_q  <= '0;
            man_l_q    <= '0;
            man_s_q    <= '0;
            sum_q      <= '0;
            sign_l_q   <= 1'b0;
            sign_s_q   <= 1'b0;
            sign_res_q <= 1'b0;
            result_q   <= '0;
`ifdef FPADD_STATUS_EN
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            inx_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_nxt;
            a_q        <= a_nxt;
            b_q        <= b_nxt;
            diff_q     <= diff_nxt;
            res_exp_q  <= res_exp_nxt;
            man_l_q    <= man_l_nxt;
            man_s_q    <= man_s_nxt;
            sum_q      <= sum_nxt;
            sign_l_q   <= sign_l_nxt;
            sign_s_q   <= sign_s_nxt;
            sign_res_q <= sign_res_nxt;
            result_q   <= result_nxt;
`ifdef FPADD_STATUS_EN
            ovf_q      <= ovf_nxt;
            zero_q     <= zero_nxt;
            inx_q      <= inx_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state_q;
        a_nxt        = a_q;
        b_nxt        = b_q;
        diff_nxt     = diff_q;
        res_exp_nxt  = res_exp_q;
        man_l_nxt    = man_l_q;
        man_s_nxt    = man_s_q;
        sum_nxt      = sum_q;
        sign_l_nxt   = sign_l_q;
        sign_s_nxt   = sign_s_q;
        sign_res_nxt = sign_res_q;
        result_nxt   = result_q;
        add_sum      = {1'b0, man_l_q} + {1'b0, man_s_q};
`ifdef FPADD_STATUS_EN
        ovf_nxt      = ovf_q;
        zero_nxt     = zero_q;
        inx_nxt      = inx_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_nxt     = op_a;
                    b_nxt     = op_b;
                    state_nxt = ST_CMP;
`ifdef FPADD_STATUS_EN
                    ovf_nxt   = 1'b0;
                    zero_nxt  = 1'b0;
                    inx_nxt   = 1'b0;
`endif
                end
            end

            ST_CMP: begin
                res_exp_nxt = cmp_exp;
                diff_nxt    = cmp_val[EXP_W-1:0];
                if (cmp_val[EXP_W]) begin
                    man_l_nxt  = man_a;
                    sign_l_nxt = a_q[SIGN_BIT];
                    man_s_nxt  = man_b;
                    sign_s_nxt = b_q[SIGN_BIT];
                end else begin
                    man_l_nxt  = man_b;
                    sign_l_nxt = b_q[SIGN_BIT];
                    man_s_nxt  = man_a;
                    sign_s_nxt = a_q[SIGN_BIT];
                end
                if (exp_a == EXP_MAX || exp_b == EXP_MAX) begin
                    result_nxt = (exp_a == EXP_MAX) ? a_q : b_q;
                    state_nxt  = ST_DONE;
                end else if (cmp_val[EXP_W-1:0] == '0) begin
                    state_nxt = ST_ADD;
                end else begin
                    state_nxt = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (diff_q >= ALIGN_LIM) begin
                    man_s_nxt = '0;
                    state_nxt = ST_ADD;
`ifdef FPADD_STATUS_EN
                    inx_nxt   = inx_q | (man_s_q != '0);
`endif
                end else begin
                    man_s_nxt = man_s_q >> 1;
                    diff_nxt  = diff_q - EXP_ONE;
`ifdef FPADD_STATUS_EN
                    inx_nxt   = inx_q | man_s_q[0];
`endif
                    if (diff_q == EXP_ONE)
                        state_nxt = ST_ADD;
                end
            end

            ST_ADD: begin
                if (sign_l_q == sign_s_q) begin
                    sign_res_nxt = sign_l_q;
                    if (add_sum[MAN_W+1]) begin
                        if (res_exp_q == EXP_TOP) begin
                            result_nxt = {sign_l_q, EXP_MAX, {MAN_W{1'b0}}};
                            state_nxt  = ST_DONE;
`ifdef FPADD_STATUS_EN
                            ovf_nxt    = 1'b1;
`endif
                        end else begin
                            sum_nxt     = add_sum[MAN_W+1:1];
                            res_exp_nxt = res_exp_q + EXP_ONE;
                            state_nxt   = ST_NORM;
`ifdef FPADD_STATUS_EN
                            inx_nxt     = inx_q | add_sum[0];
`endif
                        end
                    end else begin
                        sum_nxt   = add_sum[MAN_W:0];
                        state_nxt = ST_NORM;
                    end
                end else if (man_l_q == man_s_q) begin
                    result_nxt = '0;
                    state_nxt  = ST_DONE;
`ifdef FPADD_STATUS_EN
                    zero_nxt   = 1'b1;
`endif
                end else if (man_l_q > man_s_q) begin
                    sum_nxt      = man_l_q - man_s_q;
                    sign_res_nxt = sign_l_q;
                    state_nxt    = ST_NORM;
                end else begin
                    // Equal exponents can leave the nominally small operand with the larger mantissa.
                    sum_nxt      = man_s_q - man_l_q;
                    sign_res_nxt = sign_s_q;
                    state_nxt    = ST_NORM;
                end
            end

            ST_NORM: begin
                if (sum_q[MAN_W]) begin
                    result_nxt = {sign_res_q, res_exp_q, sum_q[MAN_HI:0]};
                    state_nxt  = ST_DONE;
                end else if (res_exp_q <= EXP_ONE) begin
                    result_nxt = '0;
                    state_nxt  = ST_DONE;
`ifdef FPADD_STATUS_EN
                    zero_nxt   = 1'b1;
`endif
                end else begin
                    sum_nxt     = sum_q << 1;
                    res_exp_nxt = res_exp_q - EXP_ONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
`ifdef FPADD_STATUS_EN
                    ovf_nxt   = 1'b0;
                    zero_nxt  = 1'b0;
                    inx_nxt   = 1'b0;
`endif
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

`ifdef FPADD_STATUS_EN
    assign flag_ovf     = ovf_q;
    assign flag_zero    = zero_q;
    assign flag_inexact = inx_q;
`endif

endmodule
